// File: rtl/register_alias_table.sv
// Register alias table: speculative map from architectural register (creg)
// to the ROB entry that will produce its value. Sources are looked up
// combinationally, with bypass from older slots of the same rename group.
// Renames set entries, matching retires clear them, flush clears them all.
module register_alias_table #(
    parameter int MACHINE_WIDTH = 2,
    parameter int ISSUE_WIDTH   = 2,
    parameter int CREG_W        = 6,
    parameter int PREG_W        = 6
) (
    input  logic                            i_clk,
    input  logic                            i_resetn,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [MACHINE_WIDTH-1:0]        i_instr_valid,
    input  logic [MACHINE_WIDTH*CREG_W-1:0] i_instr_src1,
    input  logic [MACHINE_WIDTH*CREG_W-1:0] i_instr_src2,
    input  logic [MACHINE_WIDTH*CREG_W-1:0] i_instr_dst,
    input  logic [MACHINE_WIDTH*PREG_W-1:0] i_rob_addr_new,
    input  logic [ISSUE_WIDTH-1:0]          i_retire_valid,
    input  logic [ISSUE_WIDTH*CREG_W-1:0]   i_retire_dst,
    input  logic [ISSUE_WIDTH*PREG_W-1:0]   i_retire_preg,
    output logic [MACHINE_WIDTH-1:0]        o_src1_valid,
    output logic [MACHINE_WIDTH-1:0]        o_src2_valid,
    output logic [MACHINE_WIDTH-1:0]        o_dst_valid,
    output logic [MACHINE_WIDTH*PREG_W-1:0] o_src1_id,
    output logic [MACHINE_WIDTH*PREG_W-1:0] o_src2_id,
    output logic [MACHINE_WIDTH*PREG_W-1:0] o_dst_id
);

    localparam int NUM_CREG = 2 ** CREG_W;

    // Table state: one {valid, id} pair per creg. Entry 0 is never written.
    logic [NUM_CREG-1:0] r_valid;
    logic [PREG_W-1:0]   r_id [NUM_CREG];

    // Next-state of the table.
    logic [NUM_CREG-1:0] w_valid_nxt;
    logic [PREG_W-1:0]   w_id_nxt [NUM_CREG];

    // A slot writes the table when it carries an instruction with a real dst.
    logic [MACHINE_WIDTH-1:0] w_dst_valid;

    // Destination tag outputs: the slot's own freshly allocated ROB tag.
    always_comb begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            w_dst_valid[i] = i_instr_valid[i] && (i_instr_dst[i*CREG_W +: CREG_W] != '0);
        end
    end

    assign o_dst_valid = w_dst_valid;
    assign o_dst_id    = i_rob_addr_new;

    // Source lookup: table read, overridden by the youngest older slot in the
    // group that writes the same creg; forced invalid while reset is held.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves
        // a bit unassigned, which would otherwise infer a latch.
        o_src1_valid = '0;
        o_src2_valid = '0;
        o_src1_id    = '0;
        o_src2_id    = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            o_src1_valid[i] = r_valid[i_instr_src1[i*CREG_W +: CREG_W]]
                              && (i_instr_src1[i*CREG_W +: CREG_W] != '0);
            o_src1_id[i*PREG_W +: PREG_W] = r_id[i_instr_src1[i*CREG_W +: CREG_W]];
            o_src2_valid[i] = r_valid[i_instr_src2[i*CREG_W +: CREG_W]]
                              && (i_instr_src2[i*CREG_W +: CREG_W] != '0);
            o_src2_id[i*PREG_W +: PREG_W] = r_id[i_instr_src2[i*CREG_W +: CREG_W]];
            // Ascending scan: a later (higher) matching slot overrides an earlier one.
            for (int j = 0; j < i; j++) begin
                if (i_instr_valid[j]
                    && (i_instr_dst[j*CREG_W +: CREG_W] == i_instr_src1[i*CREG_W +: CREG_W])
                    && (i_instr_src1[i*CREG_W +: CREG_W] != '0)) begin
                    o_src1_valid[i]               = 1'b1;
                    o_src1_id[i*PREG_W +: PREG_W] = i_rob_addr_new[j*PREG_W +: PREG_W];
                end
                if (i_instr_valid[j]
                    && (i_instr_dst[j*CREG_W +: CREG_W] == i_instr_src2[i*CREG_W +: CREG_W])
                    && (i_instr_src2[i*CREG_W +: CREG_W] != '0)) begin
                    o_src2_valid[i]               = 1'b1;
                    o_src2_id[i*PREG_W +: PREG_W] = i_rob_addr_new[j*PREG_W +: PREG_W];
                end
            end
            // The bypass path is purely combinational, so it is masked here too.
            if (!i_resetn) begin
                o_src1_valid[i] = 1'b0;
                o_src2_valid[i] = 1'b0;
            end
        end
    end

    // Table update: flush beats everything; renames (when not stalled) beat
    // retires on the same creg; retires clear only on an exact tag match.
    always_comb begin
        w_valid_nxt = r_valid;
        w_id_nxt    = r_id;
        if (i_flush) begin
            w_valid_nxt = '0;
        end else begin
            for (int p = 0; p < ISSUE_WIDTH; p++) begin
                if (i_retire_valid[p]
                    && (i_retire_dst[p*CREG_W +: CREG_W] != '0)
                    && r_valid[i_retire_dst[p*CREG_W +: CREG_W]]
                    && (r_id[i_retire_dst[p*CREG_W +: CREG_W]] == i_retire_preg[p*PREG_W +: PREG_W])) begin
                    w_valid_nxt[i_retire_dst[p*CREG_W +: CREG_W]] = 1'b0;
                end
            end
            if (!i_stall) begin
                // Applied after retires and in ascending slot order, so the
                // rename wins over a retire and the higher slot wins on equal dst.
                for (int i = 0; i < MACHINE_WIDTH; i++) begin
                    if (w_dst_valid[i]) begin
                        w_valid_nxt[i_instr_dst[i*CREG_W +: CREG_W]] = 1'b1;
                        w_id_nxt[i_instr_dst[i*CREG_W +: CREG_W]]    = i_rob_addr_new[i*PREG_W +: PREG_W];
                    end
                end
            end
        end
    end

    // Table registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        // NOTE: the table is built from flops, not a RAM, so every entry can and
        // must be cleared by the asynchronous reset; state uses non-blocking <=.
        if (!i_resetn) begin
            r_valid <= '0;
            for (int c = 0; c < NUM_CREG; c++) begin
                r_id[c] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            for (int c = 0; c < NUM_CREG; c++) begin
                r_id[c] <= w_id_nxt[c];
            end
        end
    end

endmodule
